// File: rtl/riscv_32_pkg.sv
// Shared type codes, opcodes and the field bundle used by the
// RV32 instruction encoder and the decoder LUT.
package riscv_32_pkg;

    localparam logic [2:0] TYPE_R = 3'b000;
    localparam logic [2:0] TYPE_I = 3'b001;
    localparam logic [2:0] TYPE_U = 3'b010;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_U = 7'b0110111;

    typedef struct packed {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/riscv_32_instr_pack.sv
// Combinational field-to-word packer for R, I and U formats.
// legal is low for any type code outside R/I/U.
module riscv_32_instr_pack
    import riscv_32_pkg::*;
(
    input  fields_t     fields,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (1'b1)
            (fields.kind == TYPE_R): begin
                legal = 1'b1;
                word  = {fields.funct7, fields.rs2, fields.rs1,
                         fields.funct3, fields.rd, OP_R};
            end
            (fields.kind == TYPE_I): begin
                legal = 1'b1;
                word  = {fields.imm[11:0], fields.rs1,
                         fields.funct3, fields.rd, OP_I};
            end
            (fields.kind == TYPE_U): begin
                legal = 1'b1;
                word  = {fields.imm[31:12], fields.rd, OP_U};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_32_instr_encoder.sv
// Encodes field bundles into RV32 words and streams them, through a
// small FIFO, to instruction memory at an auto-incrementing address.
module riscv_32_instr_encoder
    import riscv_32_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_init,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic              err,
    output logic [15:0]       count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    fields_t           fields;
    logic [31:0]       word;
    logic              legal;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occ;
    logic              live;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              push;
    logic              pop;

    assign fields = '{kind: in_type, rd: in_rd, rs1: in_rs1,
                      rs2: in_rs2, funct3: in_funct3,
                      funct7: in_funct7, imm: in_imm};

    riscv_32_instr_pack u_pack (
        .fields (fields),
        .word   (word),
        .legal  (legal)
    );

    // live keeps in_ready low for the reset cycle itself
    assign in_ready  = live && (occ < FULL);
    assign out_valid = (occ != '0);
    assign out_word  = mem[rd_ptr];
    assign out_addr  = addr;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            live   <= 1'b0;
            addr   <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            occ <= occ + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (addr_load) begin
                addr <= addr_init;
            end else if (pop) begin
                addr <= addr + ADDR_W'(1);
            end
            if (pop && (count != 16'hFFFF)) begin
                count <= count + 16'd1;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_32_instr_encoder.sv
// Directed bench for riscv_32_instr_encoder with hand-computed words.
module tb_riscv_32_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        addr_load;
    logic [9:0]  addr_init;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_addr;
    logic [31:0] out_word;
    logic        err;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    riscv_32_instr_encoder #(.ADDR_W(10), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .addr_load (addr_load),
        .addr_init (addr_init),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_word  (out_word),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [2:0] t, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_valid  = 1'b1;
        in_type   = t;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_type   = 3'b000;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        addr_load = 1'b0;
        addr_init = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_word", out_word, 32'd0);

        rst_n = 1'b1;
        step();
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // R type, latency 1
        out_ready = 1'b1;
        offer(3'b000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
        step();
        in_valid = 1'b0;
        check("r_valid", 32'(out_valid), 32'd1);
        check("r_word", out_word, 32'h002081B3);
        check("r_addr", 32'(out_addr), 32'd0);
        step();
        check("r_count", 32'(count), 32'd1);
        check("r_addr_inc", 32'(out_addr), 32'd1);
        check("r_drained", 32'(out_valid), 32'd0);

        // I then U back to back at full throughput
        offer(3'b001, 5'd5, 5'd0, 5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF);
        step();
        check("i_word", out_word, 32'hFFF00293);
        check("i_addr", 32'(out_addr), 32'd1);
        check("i_ready", 32'(in_ready), 32'd1);
        offer(3'b010, 5'd10, 5'd7, 5'd9, 3'd5, 7'h11, 32'h12345000);
        step();
        in_valid = 1'b0;
        check("u_word", out_word, 32'h12345537);
        check("u_addr", 32'(out_addr), 32'd2);
        step();
        check("iu_count", 32'(count), 32'd3);
        check("iu_drained", 32'(out_valid), 32'd0);

        // illegal type
        offer(3'b011, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h1);
        step();
        in_valid = 1'b0;
        check("ill_valid", 32'(out_valid), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_addr", 32'(out_addr), 32'd3);
        check("ill_count", 32'(count), 32'd3);
        step();
        check("ill_valid2", 32'(out_valid), 32'd0);
        check("ill_err_sticky", 32'(err), 32'd1);

        // backpressure, restart addresses at 0
        out_ready = 1'b0;
        addr_load = 1'b1;
        addr_init = 10'd0;
        step();
        addr_load = 1'b0;
        check("bp_load", 32'(out_addr), 32'd0);
        offer(3'b000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        offer(3'b000, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_word_a", out_word, 32'h000000B3);
        offer(3'b000, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_stable_word", out_word, 32'h000000B3);
        check("bp_stable_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_word_b", out_word, 32'h00000133);
        check("bp_addr_b", 32'(out_addr), 32'd1);
        check("bp_ready_again", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_word_c", out_word, 32'h000001B3);
        check("bp_addr_c", 32'(out_addr), 32'd2);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_count", 32'(count), 32'd6);

        // wrap from a fresh reset
        rst_n = 1'b0;
        step();
        check("rst2_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        addr_load = 1'b1;
        addr_init = 10'd1023;
        step();
        addr_load = 1'b0;
        check("wr_load", 32'(out_addr), 32'd1023);
        offer(3'b010, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
        step();
        check("wr_word0", out_word, 32'hABCDE0B7);
        check("wr_addr0", 32'(out_addr), 32'd1023);
        offer(3'b001, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'h00000123);
        step();
        in_valid = 1'b0;
        check("wr_word1", out_word, 32'h1231A113);
        check("wr_addr1", 32'(out_addr), 32'd0);
        step();
        check("wr_count", 32'(count), 32'd2);
        check("wr_addr_after", 32'(out_addr), 32'd1);

        // reset with two words buffered
        out_ready = 1'b0;
        offer(3'b111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        offer(3'b000, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        offer(3'b000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        in_valid = 1'b0;
        check("rb_buffered", 32'(in_ready), 32'd0);
        check("rb_err_set", 32'(err), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rb_valid", 32'(out_valid), 32'd0);
        check("rb_count", 32'(count), 32'd0);
        check("rb_err", 32'(err), 32'd0);
        out_ready = 1'b1;
        step();
        check("rb_ready", 32'(in_ready), 32'd1);
        step();
        check("rb_no_write", 32'(out_valid), 32'd0);
        check("rb_count_hold", 32'(count), 32'd0);
        check("rb_addr_hold", 32'(out_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_32_instr_encoder.md
RISCV_32_INSTR_ENCODER -- requirements
Module: riscv_32_instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 10, meaning instruction-memory word-address width.
REQ-002 Parameter DEPTH, default 2, meaning output buffer entries; legal value is 2 only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  field bundle valid.
REQ-006 in_ready  output  1  encoder accepts bundle this cycle.
REQ-007 in_type  input  3  instruction type: 000 R, 001 I, 010 U; others illegal.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3;  in_funct7  input  7.
REQ-010 in_imm  input  32  immediate; I uses [11:0], U uses [31:12].
REQ-011 addr_load  input  1;  addr_init  input  ADDR_W  load write-address counter.
REQ-012 out_valid  output  1;  out_ready  input  1  instruction-memory write handshake.
REQ-013 out_addr  output  ADDR_W;  out_word  output  32  word address and encoded instruction.
REQ-014 err  output  1  sticky illegal-type flag.
REQ-015 count  output  16  encoded instructions written, saturating at 0xFFFF.

Function
REQ-016 Input transfer occurs on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-017 R encoding: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-018 I encoding: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
REQ-019 U encoding: {imm[31:12], rd, 7'b0110111}.
REQ-020 Unused fields for a type are ignored.
REQ-021 Illegal-type bundle is accepted, produces no buffer entry, and sets err; err clears only on reset.
REQ-022 Legal bundle is written into a DEPTH-entry FIFO; earliest out_valid is the cycle after acceptance (latency 1).
REQ-023 in_ready = (occupancy < DEPTH), registered-state only; no combinational path from out_ready.
REQ-024 Full and simultaneous pop: in_ready stays 0 that cycle.
REQ-025 Non-full, simultaneous push and pop: occupancy unchanged, order preserved.
REQ-026 Sustained throughput is one instruction per cycle when out_ready is held 1.
REQ-027 out_word and out_addr hold stable while out_valid && !out_ready.
REQ-028 out_addr equals the write-address counter; counter increments by 1 per output transfer, wrapping 2^ADDR_W-1 -> 0.
REQ-029 addr_load loads addr_init and takes priority over increment in the same cycle; the FIFO is unaffected.
REQ-030 count increments per output transfer; it does not wrap.

Reset
REQ-031 On clk with rst_n=0: FIFO empty, out_valid=0, in_ready=0 in that cycle, address=0, count=0, err=0, out_word=0.
REQ-032 in_ready returns to 1 the first cycle after rst_n=1.
REQ-033 Reset mid-operation discards buffered words; no write is issued for discarded words.

Structure
REQ-034 Shared package riscv_32_pkg holds the type codes (R=000, I=001, U=010) and the opcode constants, shared with the decoder LUT.
REQ-035 The field-to-word encoding is a combinational sub-module, riscv_32_instr_pack. FIFO, address counter and flags are in the top module.

Verification
REQ-036 R: type 000, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_word 0x002081B3 at out_addr 0, next cycle.
REQ-037 I: type 001, rd=5, rs1=0, f3=0, imm=0xFFFFFFFF -> 0xFFF00293; U: type 010, rd=10, imm=0x12345000 -> 0x12345537.
REQ-038 Illegal: type 011 -> no out_valid, err=1, address and count unchanged.
REQ-039 Backpressure: out_ready=0, offer 3 legal bundles -> 2 accepted, in_ready=0; raise out_ready -> all 3 written in order at addresses 0,1,2.
REQ-040 Wrap: addr_load with 1023, two writes -> out_addr 1023 then 0; count=2.
REQ-041 Reset with 2 words buffered -> out_valid=0 next cycle, count=0, err=0, no further writes.
